rtc_calendar_core: RTL
======================

Name: rtc_calendar_core

Overview:
Parametrised time/calendar engine, successor to the fixed time-keeping stage between key debouncing and 7-segment display. Divides the board clock to a sub-second tick and cascades sub-second, second, minute, hour, day, month and year counters, with Gregorian leap-year handling. Supports per-field adjust (inc/dec/clear without carry) and a one-shot hh:mm alarm. Outputs are binary and feed the display formatter directly.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
TICK_HZ, 100, sub-second ticks per second; subsec counts 0..TICK_HZ-1; CLK_FREQ must be an integer multiple
YEAR_W, 14, year field width
YEAR_MAX, 9999, last year value before wrap to 0; must be < 2^YEAR_W
YEAR_RST, 2000, year value after reset

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  count enable; 0 freezes time, divider held
adj_en  in  1  adjust mode; freezes time, enables adj_* inputs
adj_field  in  3  0 subsec, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year, 7 none
adj_inc  in  1  single-cycle pulse: selected field +1
adj_dec  in  1  single-cycle pulse: selected field -1
adj_clr  in  1  single-cycle pulse: selected field to its minimum
alarm_arm  in  1  alarm enable
alarm_hour  in  5  alarm hour 0..23
alarm_min  in  6  alarm minute 0..59
alarm_ack  in  1  clears alarm_flag
subsec  out  8  0..TICK_HZ-1
second  out  6  0..59
minute  out  6  0..59
hour  out  5  0..23
day  out  5  1..days_in_month
month  out  4  1..12
year  out  YEAR_W  0..YEAR_MAX
leap  out  1  combinational: current year is leap
tick_1hz  out  1  one-cycle pulse when second advances by counting
alarm_flag  out  1  sticky alarm indication

Behaviour:
- Reset (rst_n=0 at a clock edge): divider 0, subsec 0, second 0, minute 0, hour 0, day 1, month 1, year YEAR_RST, tick_1hz 0, alarm_flag 0. Reset overrides every other input.
- Divider: DIV=CLK_FREQ/TICK_HZ; counts 0..DIV-1 while run=1 and adj_en=0; tick generated on the cycle the divider is DIV-1; divider returns to 0. If run=0 or adj_en=1, divider is held at 0.
- On a tick, the cascade resolves in the same cycle. subsec+1; at TICK_HZ-1 it wraps to 0 and carries. second and minute wrap 59->0. hour wraps 23->0. day wraps days_in_month->1. month wraps 12->1. year wraps YEAR_MAX->0. All outputs are registered; the new value is visible one cycle after the tick.
- days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; month 2 gives 29 if leap, else 28.
- leap = (year%4==0 && year%100!=0) || year%400==0. Year 0 counts as leap.
- tick_1hz asserts for exactly the one cycle in which the second register updates due to a subsec carry. It never asserts for adjust changes.
- Adjust applies only when adj_en=1 and adj_field<=6; otherwise adj_* inputs are ignored.
  - inc: field+1, wrapping max->min.
  - dec: field-1, wrapping min->max.
  - clr: field set to min. Min is 0, except day and month, where min is 1.
  - No carry or borrow propagates into other fields.
  - Day max is the current days_in_month.
  - Priority: clr > (inc&dec: no change) > inc/dec.
- Day clamp: when a month or year adjust makes day > new days_in_month, day is set to the new days_in_month in the same update. Example: Mar 31 dec month -> Feb 29 (leap) or Feb 28.
- Leaving adj_en: counting resumes with a fresh divider period (DIV cycles to first tick).
- Alarm: when alarm_arm=1 and a counting update produces second==0 with hour==alarm_hour and minute==alarm_min (post-update values), alarm_flag sets. alarm_flag clears on alarm_ack=1 or alarm_arm=0. Set and ack in the same cycle: set wins. Adjust-mode edits never set the flag.
- Out-of-range alarm_hour/alarm_min never match; no error is reported.

Test Plan:
Bench uses CLK_FREQ=1000, TICK_HZ=100 (DIV=10).
- Reset then run=1 for 1000 cycles -> second=1, subsec=0, exactly one tick_1hz pulse; first subsec increment occurs 10 cycles after run rises.
- Preload 2023-12-31 23:59:59 subsec 99 via adjust, exit, run 10 cycles -> 2024-01-01 00:00:00 subsec 0, leap=1.
- Leap boundaries: Feb 28 23:59:59.99 +1 tick in years 2024, 1900, 2000, 2023 -> Feb 29, Mar 1, Feb 29, Mar 1 respectively.
- Adjust: minute=59, adj_field=2, adj_inc -> minute=0 with hour unchanged; adj_inc+adj_dec in the same cycle -> no change; day=31 month=3 year=2023, adj_field=5 adj_dec -> month=2 day=28; adj_clr on month -> month=1.
- Alarm: arm 07:30, start 07:29:59.99, one tick -> alarm_flag=1 next cycle; flag holds over 200 cycles; alarm_ack -> 0; alarm_ack asserted in the setting cycle -> flag=1.
- Assert rst_n=0 mid-count at 12:34:56 with adj_en=1 -> all fields return to reset values on the next edge; tick_1hz=0, alarm_flag=0.

Source files
------------

// File: rtl/rtc_calendar_core.sv
// Real-time calendar engine: divides CLOCK_50 down to a sub-second tick and cascades
// subsec..year with Gregorian leap years, per-field adjust and a one-shot hh:mm alarm.
module rtc_calendar_core #(
   parameter int CLK_FREQ = 50000000,
   parameter int TICK_HZ  = 100,
   parameter int YEAR_W   = 14,
   parameter int YEAR_MAX = 9999,
   parameter int YEAR_RST = 2000
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic              run,
   input  logic              adj_en,
   input  logic [2:0]        adj_field,
   input  logic              adj_inc,
   input  logic              adj_dec,
   input  logic              adj_clr,
   input  logic              alarm_arm,
   input  logic [4:0]        alarm_hour,
   input  logic [5:0]        alarm_min,
   input  logic              alarm_ack,
   output logic [7:0]        subsec,
   output logic [5:0]        second,
   output logic [5:0]        minute,
   output logic [4:0]        hour,
   output logic [4:0]        day,
   output logic [3:0]        month,
   output logic [YEAR_W-1:0] year,
   output logic              leap,
   output logic              tick_1hz,
   output logic              alarm_flag
);

   localparam int DIV   = CLK_FREQ / TICK_HZ;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [7:0]        SS_MAX   = 8'(TICK_HZ - 1);
   localparam logic [YEAR_W-1:0] Y_MAX    = YEAR_W'(YEAR_MAX);
   localparam logic [YEAR_W-1:0] Y_RST    = YEAR_W'(YEAR_RST);

   typedef enum logic [1:0] {OP_NONE, OP_INC, OP_DEC, OP_CLR} adj_op_t;

   typedef enum logic [2:0] {
      F_SUBSEC = 3'd0,
      F_SEC    = 3'd1,
      F_MIN    = 3'd2,
      F_HOUR   = 3'd3,
      F_DAY    = 3'd4,
      F_MONTH  = 3'd5,
      F_YEAR   = 3'd6,
      F_NONE   = 3'd7
   } field_t;

   function automatic logic f_is_leap(input logic [YEAR_W-1:0] y);
      int unsigned v;
      v = 32'(y);
      return (((v % 4) == 0) && ((v % 100) != 0)) || ((v % 400) == 0);
   endfunction

   function automatic logic [4:0] f_dim(input logic [3:0] m, input logic lp);
      case (m)
         4'd2:                      return lp ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
         default:                   return 5'd31;
      endcase
   endfunction

   // Wrapping step within [lo, hi]; no carry leaves the field.
   function automatic int unsigned f_adjust(input int unsigned val, input int unsigned lo,
                                            input int unsigned hi, input adj_op_t op);
      case (op)
         OP_CLR:  return lo;
         OP_INC:  return (val >= hi) ? lo : val + 1;
         OP_DEC:  return (val <= lo) ? hi : val - 1;
         default: return val;
      endcase
   endfunction

   logic [DIV_W-1:0]  r_div;
   logic [7:0]        r_subsec;
   logic [5:0]        r_sec;
   logic [5:0]        r_min;
   logic [4:0]        r_hour;
   logic [4:0]        r_day;
   logic [3:0]        r_month;
   logic [YEAR_W-1:0] r_year;
   logic              r_tick_1hz;
   logic              r_alarm;

   logic [DIV_W-1:0]  w_div_nxt;
   logic [7:0]        w_subsec_nxt;
   logic [5:0]        w_sec_nxt;
   logic [5:0]        w_min_nxt;
   logic [4:0]        w_hour_nxt;
   logic [4:0]        w_day_nxt;
   logic [3:0]        w_month_nxt;
   logic [YEAR_W-1:0] w_year_nxt;
   logic              w_tick_1hz_nxt;
   logic              w_alarm_nxt;
   logic              w_alarm_hit;

   logic              w_run;
   logic              w_tick;
   logic              w_leap;
   logic [4:0]        w_dim;
   logic [4:0]        w_adj_dim;
   adj_op_t           w_op;

   logic w_c_sec, w_c_min, w_c_hour, w_c_day, w_c_month, w_c_year;

   assign w_run     = run && !adj_en;
   assign w_tick    = w_run && (r_div == DIV_LAST);
   assign w_div_nxt = (w_run && !w_tick) ? r_div + 1'b1 : '0;

   assign w_leap = f_is_leap(r_year);
   assign w_dim  = f_dim(r_month, w_leap);

   // Carry chain: each stage rolls over only when every lower stage wraps on this tick.
   assign w_c_sec   = w_tick    && (r_subsec == SS_MAX);
   assign w_c_min   = w_c_sec   && (r_sec == 6'd59);
   assign w_c_hour  = w_c_min   && (r_min == 6'd59);
   assign w_c_day   = w_c_hour  && (r_hour == 5'd23);
   assign w_c_month = w_c_day   && (r_day == w_dim);
   assign w_c_year  = w_c_month && (r_month == 4'd12);

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch is inferred.
      w_subsec_nxt   = r_subsec;
      w_sec_nxt      = r_sec;
      w_min_nxt      = r_min;
      w_hour_nxt     = r_hour;
      w_day_nxt      = r_day;
      w_month_nxt    = r_month;
      w_year_nxt     = r_year;
      w_tick_1hz_nxt = 1'b0;
      w_op           = OP_NONE;
      w_adj_dim      = w_dim;

      if (w_tick) begin
         w_subsec_nxt = w_c_sec ? '0 : r_subsec + 1'b1;
         if (w_c_sec) begin
            w_tick_1hz_nxt = 1'b1;
            w_sec_nxt      = w_c_min ? '0 : r_sec + 1'b1;
         end
         if (w_c_min)   w_min_nxt   = w_c_hour ? '0 : r_min + 1'b1;
         if (w_c_hour)  w_hour_nxt  = w_c_day ? '0 : r_hour + 1'b1;
         if (w_c_day)   w_day_nxt   = w_c_month ? 5'd1 : r_day + 1'b1;
         if (w_c_month) w_month_nxt = w_c_year ? 4'd1 : r_month + 1'b1;
         if (w_c_year)  w_year_nxt  = (r_year == Y_MAX) ? '0 : r_year + 1'b1;
      end else if (adj_en && (field_t'(adj_field) != F_NONE)) begin
         if (adj_clr)                   w_op = OP_CLR;
         else if (adj_inc && adj_dec)   w_op = OP_NONE;
         else if (adj_inc)              w_op = OP_INC;
         else if (adj_dec)              w_op = OP_DEC;

         case (field_t'(adj_field))
            F_SUBSEC: w_subsec_nxt = 8'(f_adjust(32'(r_subsec), 32'd0, 32'(SS_MAX), w_op));
            F_SEC:    w_sec_nxt    = 6'(f_adjust(32'(r_sec), 32'd0, 32'd59, w_op));
            F_MIN:    w_min_nxt    = 6'(f_adjust(32'(r_min), 32'd0, 32'd59, w_op));
            F_HOUR:   w_hour_nxt   = 5'(f_adjust(32'(r_hour), 32'd0, 32'd23, w_op));
            F_DAY:    w_day_nxt    = 5'(f_adjust(32'(r_day), 32'd1, 32'(w_dim), w_op));
            F_MONTH: begin
               w_month_nxt = 4'(f_adjust(32'(r_month), 32'd1, 32'd12, w_op));
               w_adj_dim   = f_dim(w_month_nxt, w_leap);
               if (r_day > w_adj_dim) w_day_nxt = w_adj_dim;
            end
            F_YEAR: begin
               w_year_nxt = YEAR_W'(f_adjust(32'(r_year), 32'd0, 32'(Y_MAX), w_op));
               w_adj_dim  = f_dim(r_month, f_is_leap(w_year_nxt));
               if (r_day > w_adj_dim) w_day_nxt = w_adj_dim;
            end
            default: ;
         endcase
      end

      // Alarm matches only on a counted rollover into second 0, using post-update time.
      w_alarm_hit = alarm_arm && w_c_min &&
                    (w_hour_nxt == alarm_hour) && (w_min_nxt == alarm_min);
      if (w_alarm_hit)                  w_alarm_nxt = 1'b1;
      else if (alarm_ack || !alarm_arm) w_alarm_nxt = 1'b0;
      else                              w_alarm_nxt = r_alarm;
   end

   always_ff @(posedge CLOCK_50) begin
      // NOTE: state registers use non-blocking assignment so all fields update together.
      if (!rst_n) begin
         r_div      <= '0;
         r_subsec   <= '0;
         r_sec      <= '0;
         r_min      <= '0;
         r_hour     <= '0;
         r_day      <= 5'd1;
         r_month    <= 4'd1;
         r_year     <= Y_RST;
         r_tick_1hz <= 1'b0;
         r_alarm    <= 1'b0;
      end else begin
         r_div      <= w_div_nxt;
         r_subsec   <= w_subsec_nxt;
         r_sec      <= w_sec_nxt;
         r_min      <= w_min_nxt;
         r_hour     <= w_hour_nxt;
         r_day      <= w_day_nxt;
         r_month    <= w_month_nxt;
         r_year     <= w_year_nxt;
         r_tick_1hz <= w_tick_1hz_nxt;
         r_alarm    <= w_alarm_nxt;
      end
   end

   assign subsec     = r_subsec;
   assign second     = r_sec;
   assign minute     = r_min;
   assign hour       = r_hour;
   assign day        = r_day;
   assign month      = r_month;
   assign year       = r_year;
   assign leap       = w_leap;
   assign tick_1hz   = r_tick_1hz;
   assign alarm_flag = r_alarm;

endmodule
